multicycle_control: RTL and testbench

- Multi-cycle main controller for the MIPS datapath; sequential counterpart of the single-cycle opcode decoder.
- Consumes the same opcode field (instruction[31:26]) and the same opcode set.
- Emits per-cycle datapath controls from an FSM, with memory-ready stalls and illegal-opcode trapping.
- Sits between the instruction register and the multi-cycle datapath (PC, memory, register file, ALU).

---
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Main FSM controller for the multi-cycle MIPS datapath. Walks
//             each instruction through fetch/decode/execute/memory/writeback
//             steps, stalls on memory-ready, and traps unsupported opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] instruction31_26,
  input  logic       memready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_set_illegal;

  // Raw (ungated) control decode
  logic       w_pcwrite;
  logic       w_pcwritecond;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_set_illegal;
    end
  end

  // Next-state selection; the opcode is only meaningful in DECODE and MEMADR
  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instruction31_26)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next        = S_FETCH;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (instruction31_26 == OP_LW)      w_next = S_MEMRD;
        else if (instruction31_26 == OP_SW) w_next = S_MEMWR;
        else                                w_next = S_FETCH;
      end
      S_MEMRD:  w_next = memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = memready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Moore control decode; FETCH gates PC/IR loads on memready (only Mealy term)
  always_comb begin
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    iord          = 1'b0;
    memread       = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    w_regwrite    = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    aluop         = 2'b00;
    pcsource      = 2'b00;
    case (r_state)
      S_FETCH: begin
        memread   = 1'b1;
        w_irwrite = memready;
        w_pcwrite = memready;
        alusrcb   = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        iord       = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca       = 1'b1;
        aluop         = 2'b01;
        w_pcwritecond = 1'b1;
        pcsource      = 2'b01;
      end
      S_JUMP: begin
        w_pcwrite = 1'b1;
        pcsource  = 2'b10;
      end
      default: ;
    endcase
  end

  // Write strobes are forced low while reset is held so no state is corrupted
  assign pcwrite     = w_pcwrite     & rst_n;
  assign pcwritecond = w_pcwritecond & rst_n;
  assign memwrite    = w_memwrite    & rst_n;
  assign irwrite     = w_irwrite     & rst_n;
  assign regwrite    = w_regwrite    & rst_n;

  assign illegal = r_illegal;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Randomized self-checking bench for multicycle_control. A
//             reference model walks each instruction along its list of
//             steps, holding on memory-wait steps, plus directed reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [5:0] C_OP_R   = 6'b000000;
  localparam logic [5:0] C_OP_LW  = 6'b100011;
  localparam logic [5:0] C_OP_SW  = 6'b101011;
  localparam logic [5:0] C_OP_BEQ = 6'b000100;
  localparam logic [5:0] C_OP_J   = 6'b000010;

  logic       clk;
  logic       rst_n;
  logic [5:0] instruction31_26;
  logic       memready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction31_26 (instruction31_26),
    .memready         (memready),
    .pcwrite          (pcwrite),
    .pcwritecond      (pcwritecond),
    .iord             (iord),
    .memread          (memread),
    .memwrite         (memwrite),
    .irwrite          (irwrite),
    .memtoreg         (memtoreg),
    .regdst           (regdst),
    .regwrite         (regwrite),
    .alusrca          (alusrca),
    .alusrcb          (alusrcb),
    .aluop            (aluop),
    .pcsource         (pcsource),
    .illegal          (illegal),
    .state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // All controls packed in a fixed order for comparison
  function automatic logic [15:0] pack_ctrl();
    return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
            regdst, regwrite, alusrca, alusrcb, aluop, pcsource};
  endfunction

  // Expected controls for each step of an instruction, straight from the control table
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
    logic pw = 0, pwc = 0, io = 0, mrd = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      0: begin mrd = 1; irw = mr; pw = mr; asb = 2'b01; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; io = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, io, mrd, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  // Reference model state: the step list of the current instruction
  int         path[$];
  int         idx;
  logic [5:0] cur_op;
  logic       cur_bad;
  logic       exp_illegal;

  task automatic new_instr();
    int k;
    k = $urandom_range(0, 5);
    cur_bad = 1'b0;
    case (k)
      0: begin cur_op = C_OP_LW;  path = '{0, 1, 2, 3, 4}; end
      1: begin cur_op = C_OP_SW;  path = '{0, 1, 2, 5}; end
      2: begin cur_op = C_OP_R;   path = '{0, 1, 6, 7}; end
      3: begin cur_op = C_OP_BEQ; path = '{0, 1, 8}; end
      4: begin cur_op = C_OP_J;   path = '{0, 1, 9}; end
      default: begin
        cur_bad = 1'b1;
        path = '{0, 1};
        do cur_op = 6'($urandom_range(0, 63));
        while (cur_op == C_OP_LW || cur_op == C_OP_SW || cur_op == C_OP_R ||
               cur_op == C_OP_BEQ || cur_op == C_OP_J);
      end
    endcase
    idx = 0;
  endtask

  task automatic step_state(input string tag, input int exp_st);
    @(negedge clk);
    #1;
    check(tag, 32'(state), 32'(exp_st));
  endtask

  initial begin
    int cur;
    rst_n            = 1'b0;
    memready         = 1'b0;
    instruction31_26 = 6'b000000;
    exp_illegal      = 1'b0;

    // Reset state: FETCH values, no write strobes even with memready high
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_ctrl_mr0", 32'(pack_ctrl()), 32'(exp_ctrl(0, 1'b0)));
    memready = 1'b1;
    #1;
    check("rst_pcwrite_gated", 32'(pcwrite), 32'd0);
    check("rst_irwrite_gated", 32'(irwrite), 32'd0);
    check("rst_memread", 32'(memread), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    new_instr();

    // Randomized instruction stream against the step-list model
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) @(negedge clk);
      instruction31_26 = cur_op;
      memready = ($urandom_range(0, 3) != 0);
      #1;
      cur = path[idx];
      check("state", 32'(state), 32'(cur));
      check("ctrl", 32'(pack_ctrl()), 32'(exp_ctrl(cur, memready)));
      check("illegal", 32'(illegal), 32'(exp_illegal));
      // Advance for the coming edge: memory-wait steps hold while memready is low
      if (!((cur == 0 || cur == 3 || cur == 5) && !memready)) begin
        if (cur == 1 && cur_bad) exp_illegal = 1'b1;
        idx++;
        if (idx == path.size()) new_instr();
      end
    end

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_illegal", 32'(illegal), 32'd0);

    // Unsupported opcode: DECODE returns to FETCH and sets sticky illegal
    @(negedge clk);
    rst_n            = 1'b1;
    memready         = 1'b1;
    instruction31_26 = 6'b001000;
    #1;
    check("bad_fetch", 32'(state), 32'd0);
    step_state("bad_decode", 1);
    step_state("bad_back_fetch", 0);
    check("bad_illegal_set", 32'(illegal), 32'd1);

    // sw with a three-cycle memory stall in MEMWR
    instruction31_26 = C_OP_SW;
    step_state("sw_decode", 1);
    step_state("sw_memadr", 2);
    memready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_state("sw_memwr_hold", 5);
      check("sw_memwrite", 32'(memwrite), 32'd1);
      check("sw_iord", 32'(iord), 32'd1);
      check("sw_regwrite", 32'(regwrite), 32'd0);
      check("sw_illegal_sticky", 32'(illegal), 32'd1);
    end

    // FETCH stalled: no PC/IR load
    // (first abort the store mid-cycle with an asynchronous reset)
    @(posedge clk);
    #3;
    memready = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("memwr_abort_state", 32'(state), 32'd0);
    check("memwr_abort_memwrite", 32'(memwrite), 32'd0);
    check("memwr_abort_illegal", 32'(illegal), 32'd0);
    check("memwr_abort_pcwrite", 32'(pcwrite), 32'd0);

    @(negedge clk);
    rst_n    = 1'b1;
    memready = 1'b0;
    #1;
    check("fetch_stall_pcwrite", 32'(pcwrite), 32'd0);
    check("fetch_stall_irwrite", 32'(irwrite), 32'd0);
    step_state("fetch_stall_hold", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
